// File: rtl/digit_latch_scheduler.sv
// Round-robin writer of six BCD digits onto a shared 7-segment bus with per-digit latch enables.
// Optional macro LEAD_ZERO_BLANK_EN blanks a zero on the Ht digit (index 0).
module digit_latch_scheduler #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits_in,
    input  logic        force_refresh,
    output logic [6:0]  seg_out,
    output logic [5:0]  le,
    output logic        busy,
    output logic        done
);
    localparam int unsigned NUM_DIG = 6;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, rr_ptr;
    logic [3:0]         shadow [NUM_DIG];
    logic [5:0]         dirty, dirty_nxt, changed, gnt_oh;
    logic               grant, done_nxt;
    logic [IDX_W-1:0]   gnt_idx, cand;
    logic [3:0]         gnt_val;
    logic [6:0]         gnt_seg;

    // Index 0 is Ht (bits 23:20), index 5 is So (bits 3:0)
    function automatic logic [3:0] digit_at(input logic [23:0] d, input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    return d[23:20];
            3'd1:    return d[19:16];
            3'd2:    return d[15:12];
            3'd3:    return d[11:8];
            3'd4:    return d[7:4];
            3'd5:    return d[3:0];
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Circular search for the first dirty digit at or after rr_ptr; grants only from IDLE
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_DIG);
            if (state == IDLE && !grant && dirty[cand]) begin
                grant   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_val = digit_at(digits_in, gnt_idx);
`ifdef LEAD_ZERO_BLANK_EN
        gnt_seg = (gnt_idx == '0 && gnt_val == 4'd0) ? 7'b0000000 : enc(gnt_val);
`else
        gnt_seg = enc(gnt_val);
`endif
        gnt_oh  = grant ? (6'(1) << gnt_idx) : 6'(0);
    end

    // The granted digit's shadow is refreshed on the same edge, so its compare is masked there
    always_comb begin
        changed = '0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            changed[i] = (digit_at(digits_in, IDX_W'(i)) != shadow[i]);
        end
        dirty_nxt = ((changed | dirty) & ~gnt_oh) | {NUM_DIG{force_refresh}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_nxt = STROBE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == CNT_W'(STROBE_CYC - 1)) begin
                    state_nxt = (HOLD_CYC == 0) ? IDLE : HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        done_nxt = ((state_nxt == STROBE) && (cnt_nxt == CNT_W'(STROBE_CYC - 1)) && (HOLD_CYC == 0))
                 || ((state_nxt == HOLD) && (cnt_nxt == CNT_W'(HOLD_CYC - 1)));
    end

    // Outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            rr_ptr  <= '0;
            dirty   <= '1;
            seg_out <= '0;
            le      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < int'(NUM_DIG); i++) begin
                shadow[i] <= '0;
            end
        end else begin
            dirty <= dirty_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
            le    <= (state_nxt == STROBE) ? (6'(1) << idx) : 6'(0);
            if (grant) begin
                idx             <= gnt_idx;
                shadow[gnt_idx] <= gnt_val;
                seg_out         <= gnt_seg;
                rr_ptr          <= (gnt_idx == IDX_W'(NUM_DIG - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_digit_latch_scheduler.sv
// Bench for digit_latch_scheduler: expected (index, segment) writes are queued as digits are
// driven and popped at each latch-enable rising edge; directed tasks cover timing and reset.
`timescale 1ns/1ps
module tb_digit_latch_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits_in;
    logic        force_refresh;
    logic [6:0]  seg_out;
    logic [5:0]  le;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [2:0] idx;
        logic [6:0] seg;
    } exp_t;

    exp_t       sb[$];
    int         checks     = 0;
    int         failures   = 0;
    int         le_events  = 0;
    int         done_count = 0;
    int         width      = 0;
    logic [5:0] le_prev    = '0;
    logic [6:0] latch [6];

    always #5 clk = ~clk;

    digit_latch_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .digits_in    (digits_in),
        .force_refresh(force_refresh),
        .seg_out      (seg_out),
        .le           (le),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [6:0] enc_ref(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int i, input logic [3:0] v);
`ifdef LEAD_ZERO_BLANK_EN
        if (i == 0 && v == 4'd0) return 7'b0000000;
`endif
        return enc_ref(v);
    endfunction

    function automatic logic [3:0] dig(input logic [23:0] d, input int i);
        return d[4*(5-i) +: 4];
    endfunction

    task automatic push(input int i, input logic [3:0] v);
        exp_t e;
        e.idx = 3'(i);
        e.seg = exp_seg(i, v);
        sb.push_back(e);
    endtask

    // Latch model, one-hot check, pulse width and in-order scoreboard pop
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            le_prev = '0;
            width   = 0;
        end else begin
            checks++;
            if (!$onehot0(le)) begin
                failures++;
                $display("FAIL le_onehot le=%b required one-hot-or-zero", le);
            end
            if (done) done_count++;
            for (int i = 0; i < 6; i++) if (le[i]) latch[i] = seg_out;
            if (le != 6'd0 && le_prev == 6'd0) begin
                le_events++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL le_unexpected le=%b required no write", le);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (le !== (6'd1 << e.idx)) begin
                        failures++;
                        $display("FAIL le_order le=%b required=%b", le, 6'd1 << e.idx);
                    end
                    checks++;
                    if (seg_out !== e.seg) begin
                        failures++;
                        $display("FAIL seg_value idx=%0d seg_out=%b required=%b", e.idx, seg_out, e.seg);
                    end
                end
            end
            if (le != 6'd0) begin
                width++;
            end else if (le_prev != 6'd0) begin
                checks++;
                if (width != 1) begin
                    failures++;
                    $display("FAIL le_width got=%0d required=1", width);
                end
                width = 0;
            end
            le_prev = le;
        end
    end

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int c = 0; c < 300 && quiet < 4; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 4) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d busy=%b required drained and idle", tag, sb.size(), busy);
        end
    endtask

    task automatic test_reset;
        int last_busy = -1;
        int ev0;
        int dn0;
        rst = 1'b1;
        force_refresh = 1'b0;
        digits_in = 24'h123456;
        repeat (3) @(negedge clk);
        checks++; if (seg_out !== 7'd0) begin failures++; $display("FAIL rst_seg got=%b required=0", seg_out); end
        checks++; if (le !== 6'd0)      begin failures++; $display("FAIL rst_le got=%b required=0", le); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL rst_done got=%b required=0", done); end
        for (int i = 0; i < 6; i++) push(i, dig(digits_in, i));
        ev0 = le_events;
        dn0 = done_count;
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) last_busy = n;
        end
        checks++;
        if (last_busy + 1 != 24) begin
            failures++;
            $display("FAIL busy_fall got=%0d required=24", last_busy + 1);
        end
        checks++; if (le_events - ev0 != 6) begin failures++; $display("FAIL refresh_count got=%0d required=6", le_events - ev0); end
        checks++; if (done_count - dn0 != 6) begin failures++; $display("FAIL refresh_done got=%0d required=6", done_count - dn0); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL refresh_pending got=%0d required=0", sb.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (latch[i] !== enc_ref(4'(i + 1))) begin
                failures++;
                $display("FAIL refresh_latch idx=%0d got=%b required=%b", i, latch[i], enc_ref(4'(i + 1)));
            end
        end
    endtask

    task automatic test_single_change;
        int first = -1;
        int other = 0;
        int dn0;
        @(negedge clk);
        digits_in = 24'h123457;
        push(5, 4'd7);
        dn0 = done_count;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (le[5] && first < 0) first = c;
            if (le[4:0] != 5'd0) other++;
            if (c <= 3) begin
                checks++;
                if (seg_out !== 7'b1110000) begin
                    failures++;
                    $display("FAIL single_seg cycle=%0d got=%b required=1110000", c, seg_out);
                end
            end
        end
        checks++; if (first != 2) begin failures++; $display("FAIL single_latency got=%0d required=2", first); end
        checks++; if (other != 0) begin failures++; $display("FAIL single_other_le got=%0d required=0", other); end
        wait_idle("single");
        checks++; if (done_count - dn0 != 1) begin failures++; $display("FAIL single_done got=%0d required=1", done_count - dn0); end
    endtask

    task automatic test_round_robin;
        @(negedge clk);
        digits_in = 24'h123467;
        push(4, 4'd6);
        wait_idle("rr_prep");
        @(negedge clk);
        digits_in = 24'h123489;
        push(5, 4'd9);
        push(4, 4'd8);
        wait_idle("rr");
        checks++; if (latch[4] !== enc_ref(4'd8)) begin failures++; $display("FAIL rr_latch4 got=%b required=%b", latch[4], enc_ref(4'd8)); end
        checks++; if (latch[5] !== enc_ref(4'd9)) begin failures++; $display("FAIL rr_latch5 got=%b required=%b", latch[5], enc_ref(4'd9)); end
    endtask

    task automatic test_change_during_strobe;
        bit found = 0;
        @(negedge clk);
        digits_in = 24'h123487;
        push(5, 4'd7);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (le[5]) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL strobe_wait got=no le[5] required=le[5] high"); end
        digits_in = 24'h123488;
        push(5, 4'd8);
        wait_idle("restrobe");
        checks++; if (latch[5] !== enc_ref(4'd8)) begin failures++; $display("FAIL restrobe_latch got=%b required=%b", latch[5], enc_ref(4'd8)); end
    endtask

    task automatic test_blank;
        logic [6:0] zero_req;
        @(negedge clk);
        digits_in = 24'hA23488;
        push(0, 4'hA);
        wait_idle("blank_a");
        checks++; if (latch[0] !== 7'b0000000) begin failures++; $display("FAIL blank_a got=%b required=0000000", latch[0]); end
        @(negedge clk);
        digits_in = 24'h023488;
        push(0, 4'd0);
        wait_idle("blank_zero");
`ifdef LEAD_ZERO_BLANK_EN
        zero_req = 7'b0000000;
`else
        zero_req = 7'b1111110;
`endif
        checks++; if (latch[0] !== zero_req) begin failures++; $display("FAIL ht_zero got=%b required=%b", latch[0], zero_req); end
    endtask

    task automatic test_force_refresh;
        @(negedge clk);
        force_refresh = 1'b1;
        for (int k = 0; k < 6; k++) push((1 + k) % 6, dig(digits_in, (1 + k) % 6));
        @(negedge clk);
        force_refresh = 1'b0;
        wait_idle("force");
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        @(negedge clk);
        digits_in = 24'h025488;
        push(2, 4'd5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (le[2]) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL midrst_wait got=no le[2] required=le[2] high"); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (le !== 6'd0)      begin failures++; $display("FAIL midrst_le got=%b required=0", le); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got=%b required=0", busy); end
        checks++; if (seg_out !== 7'd0) begin failures++; $display("FAIL midrst_seg got=%b required=0", seg_out); end
        sb.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(i, dig(digits_in, i));
        rst = 1'b0;
        wait_idle("midrst");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (latch[i] !== exp_seg(i, dig(digits_in, i))) begin
                failures++;
                $display("FAIL midrst_latch idx=%0d got=%b required=%b", i, latch[i], exp_seg(i, dig(digits_in, i)));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_change();
        test_round_robin();
        test_change_during_strobe();
        test_blank();
        test_force_refresh();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
